// File: rtl/calc_pkg.sv
// Shared definitions for the calculator operand memory: sizes, word type and
// the writer's state encoding (the reader side imports this package as well).
package calc_pkg;

   localparam int CALC_DATA_W = 16;
   localparam int CALC_DEPTH  = 512;
   localparam int CALC_ADDR_W = 10;

   typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DONE} writer_state_t;

   typedef logic [CALC_DATA_W-1:0] calc_word_t;

endpackage

// File: rtl/calc_mem_writer_if.sv
// Bundles the incoming valid/ready word stream with the memory write port.
// The master side is the writer block; the slave side is the source plus memory.
interface calc_mem_writer_if
   import calc_pkg::*;
#(
   parameter int DATA_W = CALC_DATA_W,
   parameter int ADDR_W = CALC_ADDR_W
);

   logic              valid;
   logic [DATA_W-1:0] in_data;
   logic              ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;

   modport master (
      input  valid,
      input  in_data,
      output ready,
      output mem_we,
      output mem_addr,
      output mem_wdata
   );

   modport slave (
      output valid,
      output in_data,
      input  ready,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata
   );

endinterface

// File: rtl/calc_mem_writer.sv
// Zero-fills the operand memory, then stores a word stream as A,B pairs until a
// B==0 terminator pair has been written or the memory is full.
module calc_mem_writer
   import calc_pkg::*;
#(
   parameter int DATA_W = CALC_DATA_W,
   parameter int DEPTH  = CALC_DEPTH,
   parameter int ADDR_W = CALC_ADDR_W
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   calc_mem_writer_if.master bus,
   output logic [ADDR_W-1:0] pair_count,
   output logic              busy,
   output logic              terminate
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   writer_state_t     state;
   writer_state_t     next_state;
   logic [ADDR_W-1:0] word_cnt;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_pending;
   logic              stop_pending;
   logic              accept;
   logic              is_b;
   logic              b_zero;

   assign accept = bus.valid & bus.ready;
   assign is_b   = word_cnt[0];
   assign b_zero = is_b && (bus.in_data == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE, DONE: if (start) next_state = CLEAR;
         CLEAR:      if (word_cnt == LAST_ADDR) next_state = LOAD;
         LOAD:       if (stop_pending) next_state = DONE;
         default:    next_state = IDLE;
      endcase
   end

   // CLEAR drives the sweep straight from the counter; LOAD replays the word
   // registered on the previous accept, so the write lags the handshake by one cycle.
   always_comb begin
      bus.ready     = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      busy          = 1'b0;
      terminate     = 1'b0;
      case (state)
         CLEAR: begin
            bus.mem_we   = 1'b1;
            bus.mem_addr = word_cnt;
            busy         = 1'b1;
         end
         LOAD: begin
            bus.ready     = !stop_pending;
            bus.mem_we    = wr_pending;
            bus.mem_addr  = wr_addr;
            bus.mem_wdata = wr_data;
            busy          = 1'b1;
         end
         DONE:    terminate = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         word_cnt     <= '0;
         pair_count   <= '0;
         wr_pending   <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         stop_pending <= 1'b0;
      end else begin
         wr_pending <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  word_cnt     <= '0;
                  pair_count   <= '0;
                  stop_pending <= 1'b0;
               end
            end
            CLEAR: begin
               word_cnt <= (word_cnt == LAST_ADDR) ? '0 : word_cnt + ADDR_W'(1);
            end
            LOAD: begin
               // stop_pending closes ready for the cycle the final word is written
               if (accept) begin
                  wr_pending <= 1'b1;
                  wr_addr    <= word_cnt;
                  wr_data    <= bus.in_data;
                  word_cnt   <= word_cnt + ADDR_W'(1);
                  if (is_b && !b_zero) begin
                     pair_count <= pair_count + ADDR_W'(1);
                  end
                  if (b_zero || (word_cnt == LAST_ADDR)) begin
                     stop_pending <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_mem_writer.sv
// Scoreboard bench for calc_mem_writer: stimulus pushes expected memory writes,
// a monitor pops them as the DUT writes, and the final image is compared.
module tb_calc_mem_writer;
   import calc_pkg::*;

   localparam int DEPTH = CALC_DEPTH;

   typedef struct packed {
      logic [CALC_ADDR_W-1:0] addr;
      calc_word_t             data;
   } wr_t;

   logic                   clk = 1'b0;
   logic                   reset = 1'b1;
   logic                   start = 1'b0;
   logic [CALC_ADDR_W-1:0] pair_count;
   logic                   busy;
   logic                   terminate;

   calc_mem_writer_if bus ();

   calc_mem_writer dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .bus        (bus),
      .pair_count (pair_count),
      .busy       (busy),
      .terminate  (terminate)
   );

   always #5 clk = ~clk;

   int         assert_count = 0;
   int         fail_count   = 0;
   wr_t        exp_q[$];
   calc_word_t tb_mem[DEPTH];
   calc_word_t exp_mem[DEPTH];
   calc_word_t stream[$];
   int         gap_cycles;
   wr_t        mon_entry;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      assert_count++;
      if (actual !== required) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
      end
   endtask

   // Plays the external memory and checks each write against the scoreboard.
   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         if (bus.mem_addr < CALC_ADDR_W'(DEPTH)) tb_mem[bus.mem_addr[8:0]] = bus.mem_wdata;
         if (exp_q.size() == 0) begin
            assert_count++;
            fail_count++;
            $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                     bus.mem_addr, bus.mem_wdata);
         end else begin
            mon_entry = exp_q.pop_front();
            checkOutput("write", {6'd0, bus.mem_addr, bus.mem_wdata}, {6'd0, mon_entry});
         end
      end
   end

   task automatic pushClearSweep();
      for (int i = 0; i < DEPTH; i++) exp_q.push_back({CALC_ADDR_W'(i), 16'h0000});
   endtask

   // Called on a falling edge with the DUT in IDLE or DONE.
   task automatic startImage(input bit with_valid);
      int n;
      int nonzero;
      foreach (tb_mem[i]) tb_mem[i] = 16'hFFFF;
      start = 1'b1;
      if (with_valid) begin
         bus.valid   = 1'b1;
         bus.in_data = 16'hABCD;
      end
      pushClearSweep();
      @(negedge clk);
      start     = 1'b0;
      bus.valid = 1'b0;
      checkOutput("start_terminate", terminate, 0);
      checkOutput("start_pairs", pair_count, 0);
      checkOutput("start_busy", busy, 1);
      checkOutput("start_ready", bus.ready, 0);
      n = 0;
      while (!bus.ready && n < 600) begin
         n++;
         @(negedge clk);
      end
      checkOutput("clear_cycles", n, 512);
      checkOutput("clear_queue", exp_q.size(), 0);
      nonzero = 0;
      foreach (tb_mem[i]) if (tb_mem[i] !== 16'h0000) nonzero++;
      checkOutput("clear_image", nonzero, 0);
      foreach (exp_mem[i]) exp_mem[i] = 16'h0000;
   endtask

   // Offers one word and waits (bounded) for the handshake.
   task automatic applyStimulus(input calc_word_t w, output bit ok);
      int n = 0;
      bus.valid   = 1'b1;
      bus.in_data = w;
      while (!bus.ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      ok = bus.ready;
   endtask

   // Reference: word k lands at address k; the image ends at the first odd
   // address holding 0 or at the last address; pairs counts nonzero B words.
   task automatic runLoad();
      int  pairs = 0;
      bit  ended = 0;
      bit  ok;
      bit  last;
      int  g;
      int  mism;
      calc_word_t w;
      for (int k = 0; k < stream.size() && !ended; k++) begin
         w    = stream[k];
         last = ((k % 2) == 1 && w == 16'h0000) || (k == DEPTH - 1);
         applyStimulus(w, ok);
         if (!ok) begin
            checkOutput("ready_timeout", 0, 1);
            bus.valid = 1'b0;
            break;
         end
         exp_q.push_back({CALC_ADDR_W'(k), w});
         exp_mem[k] = w;
         if ((k % 2) == 1 && w != 16'h0000) pairs++;
         @(negedge clk);
         bus.valid = 1'b0;
         checkOutput("pair_count", pair_count, pairs);
         checkOutput("ready_after_word", bus.ready, {31'd0, !last});
         if (last) begin
            checkOutput("terminate_early", terminate, 0);
            @(negedge clk);
            checkOutput("terminate", terminate, 1);
            checkOutput("done_busy", busy, 0);
            checkOutput("done_ready", bus.ready, 0);
            ended = 1;
         end else begin
            g = (gap_cycles < 0) ? int'($urandom_range(0, 3)) : gap_cycles;
            repeat (g) @(negedge clk);
         end
      end
      checkOutput("stream_terminated", ended, 1);
      checkOutput("final_pairs", pair_count, pairs);
      repeat (3) @(negedge clk);
      checkOutput("load_queue", exp_q.size(), 0);
      mism = 0;
      foreach (tb_mem[i]) if (tb_mem[i] !== exp_mem[i]) mism++;
      checkOutput("image", mism, 0);
   endtask

   task automatic buildRandomStream();
      int np = int'($urandom_range(1, 12));
      stream.delete();
      for (int p = 0; p < np; p++) begin
         stream.push_back(($urandom_range(0, 4) == 0) ? 16'h0000 : calc_word_t'($urandom));
         if (p == np - 1)                stream.push_back(16'h0000);
         else if ($urandom_range(0, 9) == 0) stream.push_back(16'h0000);
         else                            stream.push_back(calc_word_t'($urandom_range(1, 65535)));
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit seen;
      bus.valid   = 1'b0;
      bus.in_data = '0;
      reset       = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("reset_flags", {bus.ready, bus.mem_we, busy, terminate}, 0);
      checkOutput("reset_addr", bus.mem_addr, 0);
      checkOutput("reset_wdata", bus.mem_wdata, 0);
      checkOutput("reset_pairs", pair_count, 0);
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] reset during clear sweep");
      start = 1'b1;
      pushClearSweep();
      @(negedge clk);
      start = 1'b0;
      repeat (99) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #2;
      exp_q.delete();
      @(negedge clk);
      checkOutput("midclear_we", bus.mem_we, 0);
      checkOutput("midclear_flags", {bus.ready, busy, terminate}, 0);
      checkOutput("midclear_addr", bus.mem_addr, 0);
      checkOutput("midclear_pairs", pair_count, 0);
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] normal load");
      startImage(0);
      stream = '{16'd12, 16'd4, 16'd7, 16'd9, 16'd5, 16'd0};
      gap_cycles = 0;
      runLoad();
      checkOutput("normal_pairs", pair_count, 2);

      $display("[TB] A equal to zero is data");
      startImage(0);
      stream = '{16'd0, 16'd3, 16'd8, 16'd0};
      runLoad();
      checkOutput("azero_pairs", pair_count, 1);

      $display("[TB] full memory");
      startImage(0);
      stream.delete();
      for (int i = 0; i < DEPTH / 2; i++) begin
         stream.push_back(calc_word_t'(i));
         stream.push_back(calc_word_t'(i + 1));
      end
      runLoad();
      checkOutput("full_pairs", pair_count, 256);
      checkOutput("full_last_data", tb_mem[DEPTH-1], 256);
      bus.valid   = 1'b1;
      bus.in_data = 16'h1234;
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.ready) seen = 1;
      end
      bus.valid = 1'b0;
      checkOutput("full_extra_ready", seen, 0);

      $display("[TB] stalled load and restart");
      startImage(0);
      stream = '{16'd12, 16'd4, 16'd7, 16'd9, 16'd5, 16'd0};
      gap_cycles = 3;
      runLoad();
      checkOutput("stall_pairs", pair_count, 2);
      startImage(1);

      $display("[TB] random loads");
      gap_cycles = -1;
      for (int r = 0; r < 3; r++) begin
         if (r > 0) startImage(0);
         buildRandomStream();
         runLoad();
      end

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
